// File: rtl/wxyz_acc_sched.sv
// rtl/wxyz_acc_sched.sv - tile burst scheduler and checksum checker; optional DRAIN watchdog via WXYZ_SCHED_TIMEOUT_EN
module wxyz_acc_sched #(
  parameter int arraySize    = 4,
  parameter int addressWidth = 2,
  parameter int zBits        = 28,
  parameter int tileBits     = 8,
  parameter int maxOut       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [tileBits-1:0] num_tiles,
  input  logic                tile_avail,
  output logic                src_pop,
  output logic                acc_valid,
  input  logic                acc_valid_out,
  input  logic [zBits-1:0]    w_acc,
  input  logic [zBits-1:0]    x_acc,
  input  logic [zBits-1:0]    y_acc,
  input  logic [zBits-1:0]    z_acc,
  input  logic                exp_valid,
  input  logic [zBits-1:0]    exp_w,
  input  logic [zBits-1:0]    exp_x,
  input  logic [zBits-1:0]    exp_y,
  input  logic [zBits-1:0]    exp_z,
  output logic                exp_pop,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [tileBits-1:0] err_cnt,
  output logic [tileBits-1:0] err_tile
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [addressWidth-1:0] LAST_BEAT = addressWidth'(arraySize - 1);
  localparam logic [tileBits-1:0]     MAX_OUT   = tileBits'(maxOut);
  localparam logic [tileBits-1:0]     CNT_SAT   = {tileBits{1'b1}};

  state_t                  state_q, state_d;
  logic [tileBits-1:0]     num_q, num_d;
  logic [tileBits-1:0]     issued_q, issued_d;
  logic [tileBits-1:0]     checked_q, checked_d;
  logic [addressWidth-1:0] beat_q, beat_d;
  logic                    burst_q, burst_d;
  logic                    err_q, err_d;
  logic [tileBits-1:0]     err_cnt_q, err_cnt_d;
  logic [tileBits-1:0]     err_tile_q, err_tile_d;

  logic [tileBits-1:0]     outstanding;
  logic                    launch;
  logic                    beat_on;
  logic                    last_beat;
  logic                    check_en;
  logic                    mismatch;

`ifdef WXYZ_SCHED_TIMEOUT_EN
  logic [15:0]             wd_q, wd_d;
  logic                    wd_fire;
`endif

  // Burst launch, beat activity and result-check qualification
  always_comb begin
    outstanding = issued_q - checked_q;
    launch      = (state_q == ISSUE) && !burst_q && tile_avail &&
                  (outstanding < MAX_OUT) && (issued_q < num_q);
    // The accumulator clears on any idle cycle, so once launched a burst
    // runs to its last beat regardless of tile_avail.
    beat_on     = (state_q == ISSUE) && (burst_q || launch);
    last_beat   = beat_on && (beat_q == LAST_BEAT);
    check_en    = acc_valid_out && ((state_q == ISSUE) || (state_q == DRAIN));
    mismatch    = check_en && (!exp_valid ||
                               (w_acc != exp_w) || (x_acc != exp_x) ||
                               (y_acc != exp_y) || (z_acc != exp_z));
`ifdef WXYZ_SCHED_TIMEOUT_EN
    // A check in the same cycle restarts the count, so it cannot fire then.
    wd_fire     = (state_q == DRAIN) && !check_en && (wd_q == 16'hFFFF);
`endif
  end

  // Next-state logic of the job FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_tiles == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issued_q == num_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (checked_q == num_q) begin
          state_d = DONE;
        end
`ifdef WXYZ_SCHED_TIMEOUT_EN
        else if (wd_fire) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job counters, beat counter and error bookkeeping
  always_comb begin
    num_d      = num_q;
    issued_d   = issued_q;
    checked_d  = checked_q;
    beat_d     = beat_q;
    burst_d    = burst_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_tile_d = err_tile_q;

    // A new job wipes the previous job's counters and error record.
    if ((state_q == IDLE) && start) begin
      num_d      = num_tiles;
      issued_d   = '0;
      checked_d  = '0;
      beat_d     = '0;
      burst_d    = 1'b0;
      err_d      = 1'b0;
      err_cnt_d  = '0;
      err_tile_d = '0;
    end

    if (beat_on) begin
      beat_d  = last_beat ? '0 : beat_q + 1'b1;
      burst_d = !last_beat;
      if (last_beat) begin
        issued_d = issued_q + 1'b1;
      end
    end

    if (check_en) begin
      checked_d = checked_q + 1'b1;
      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != CNT_SAT) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        // Only the first bad tile of a job is recorded.
        if (!err_q) begin
          err_tile_d = checked_q;
        end
      end
    end

`ifdef WXYZ_SCHED_TIMEOUT_EN
    if (wd_fire) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_tile_d = checked_q;
      end
    end
`endif
  end

`ifdef WXYZ_SCHED_TIMEOUT_EN
  // DRAIN watchdog: restarts on entry to DRAIN and on each result strobe
  always_comb begin
    wd_d = wd_q;
    if (((state_q == ISSUE) && (state_d == DRAIN)) || check_en) begin
      wd_d = '0;
    end else if (state_q == DRAIN) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      checked_q  <= '0;
      beat_q     <= '0;
      burst_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_tile_q <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      checked_q  <= checked_d;
      beat_q     <= beat_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_tile_q <= err_tile_d;
    end
  end

  // Outputs decode straight from state so reset removes them at once
  always_comb begin
    acc_valid = beat_on;
    src_pop   = beat_on;
    exp_pop   = check_en;
    busy      = (state_q == ISSUE) || (state_q == DRAIN);
    done      = (state_q == DONE);
    err       = err_q;
    err_cnt   = err_cnt_q;
    err_tile  = err_tile_q;
  end

endmodule

// File: tb/tb_wxyz_acc_sched.sv
// tb/tb_wxyz_acc_sched.sv - scoreboard bench for wxyz_acc_sched
module tb_wxyz_acc_sched;

  localparam int AS = 4;
  localparam int AW = 2;
  localparam int ZB = 28;
  localparam int TW = 8;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          tile_avail;
  logic          src_pop;
  logic          acc_valid;
  logic          acc_valid_out;
  logic [ZB-1:0] w_acc, x_acc, y_acc, z_acc;
  logic          exp_valid;
  logic [ZB-1:0] exp_w, exp_x, exp_y, exp_z;
  logic          exp_pop;
  logic          busy;
  logic          done;
  logic          err;
  logic [TW-1:0] err_cnt;
  logic [TW-1:0] err_tile;

  wxyz_acc_sched #(
    .arraySize(AS), .addressWidth(AW), .zBits(ZB), .tileBits(TW), .maxOut(MO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .tile_avail(tile_avail), .src_pop(src_pop), .acc_valid(acc_valid),
    .acc_valid_out(acc_valid_out),
    .w_acc(w_acc), .x_acc(x_acc), .y_acc(y_acc), .z_acc(z_acc),
    .exp_valid(exp_valid),
    .exp_w(exp_w), .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
    .exp_pop(exp_pop), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .err_tile(err_tile)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          e;
    bit [TW-1:0] c;
    bit [TW-1:0] t;
  } sb_t;

  sb_t sb_q[$];
  int  pending[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model of the error record, updated as each result is presented
  bit          m_err;
  bit [TW-1:0] m_cnt;
  bit [TW-1:0] m_tile;
  bit          bad_y[16];
  bit          no_exp[16];

  int  resp_budget;
  int  resp_cyc;
  bit  man_req;
  bit  exp_pop_exp;
  bit  expect_partial;
  bit  chk_due = 1'b0;

  int tile_idx, beat, run, max_run, n_runs, last_run_start, total_beats;
  int done_cnt, n_busy, n_pops;

  always @(posedge clk) cyc <= cyc + 1;

  // accumulator/expected-checksum source: answers each finished tile one cycle later
  initial begin : responder
    int       t;
    bit       mism;
    sb_t      se;
    logic [ZB-1:0] d;
    acc_valid_out = 1'b0; exp_valid = 1'b0;
    w_acc = '0; x_acc = '0; y_acc = '0; z_acc = '0;
    exp_w = '0; exp_x = '0; exp_y = '0; exp_z = '0;
    exp_pop_exp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      acc_valid_out = 1'b0;
      exp_valid     = 1'b0;
      exp_pop_exp   = 1'b0;
      if (man_req) begin
        man_req       = 1'b0;
        acc_valid_out = 1'b1;
        exp_valid     = 1'b1;
        w_acc         = ZB'(5);
        exp_w         = ZB'(6);
      end else if (pending.size() > 0 && resp_budget > 0) begin
        t = pending.pop_front();
        resp_budget--;
        resp_cyc = cyc;
        d = ZB'($urandom); w_acc = d; exp_w = d;
        d = ZB'($urandom); x_acc = d; exp_x = d;
        d = ZB'($urandom); y_acc = d; exp_y = bad_y[t % 16] ? d + 1'b1 : d;
        d = ZB'($urandom); z_acc = d; exp_z = d;
        exp_valid     = !no_exp[t % 16];
        acc_valid_out = 1'b1;
        exp_pop_exp   = 1'b1;
        mism = bad_y[t % 16] || no_exp[t % 16];
        if (mism) begin
          if (!m_err) m_tile = TW'(t);
          m_err = 1'b1;
          if (m_cnt != {TW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        se.e = m_err; se.c = m_cnt; se.t = m_tile;
        sb_q.push_back(se);
      end
    end
  end

  // output monitor: burst framing, exp_pop strobes and per-check error record
  always @(negedge clk) begin
    sb_t e;
    if (chk_due) begin
      n_assert++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: err=%0b cnt=%0d tile=%0d with no expected entry", err, err_cnt, err_tile);
      end else begin
        e = sb_q.pop_front();
        if ({err, err_cnt, err_tile} !== {e.e, e.c, e.t}) begin
          n_fail++;
          $display("FAIL check_result: got err=%0b cnt=%0d tile=%0d expected err=%0b cnt=%0d tile=%0d",
                   err, err_cnt, err_tile, e.e, e.c, e.t);
        end
      end
    end
    chk_due = (exp_pop === 1'b1);
    if (exp_pop === 1'b1) n_pops++;
    if (acc_valid_out === 1'b1 || exp_pop === 1'b1) begin
      n_assert++;
      if (exp_pop !== exp_pop_exp) begin
        n_fail++;
        $display("FAIL exp_pop: got %b expected %b at cycle %0d", exp_pop, exp_pop_exp, cyc);
      end
    end
    if (acc_valid === 1'b1 || src_pop === 1'b1) begin
      n_assert++;
      if (src_pop !== acc_valid) begin
        n_fail++;
        $display("FAIL src_pop: got %b expected %b", src_pop, acc_valid);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) n_busy++;
    if (acc_valid === 1'b1) begin
      if (run == 0) begin
        last_run_start = cyc;
        n_runs++;
      end
      run++;
      if (run > max_run) max_run = run;
      total_beats++;
      beat++;
      if (beat == AS) begin
        pending.push_back(tile_idx);
        tile_idx++;
        beat = 0;
      end
    end else begin
      if (run != 0 && !expect_partial) begin
        n_assert++;
        if (beat != 0) begin
          n_fail++;
          $display("FAIL burst_len: run ended mid-tile after %0d beats, expected multiple of %0d", beat, AS);
        end
      end
      run  = 0;
      beat = 0;
    end
  end

  task automatic job_clear();
    tile_idx = 0; beat = 0; run = 0; max_run = 0; n_runs = 0;
    last_run_start = -1; total_beats = 0; done_cnt = 0; n_busy = 0; n_pops = 0;
    pending.delete();
    sb_q.delete();
    m_err = 1'b0; m_cnt = '0; m_tile = '0;
    for (int i = 0; i < 16; i++) begin
      bad_y[i]  = 1'b0;
      no_exp[i] = 1'b0;
    end
    resp_budget = 1000;
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_tiles = TW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_assert++;
    if ({acc_valid, src_pop, exp_pop, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {acc_valid, src_pop, exp_pop, busy, done, err});
    end
    n_assert++;
    if ({err_cnt, err_tile} !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got cnt=%0d tile=%0d expected 0 0", err_cnt, err_tile);
    end
    start = 1'b1; num_tiles = 8'd3; tile_avail = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({acc_valid, src_pop, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 0000", {acc_valid, src_pop, busy, done});
    end
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({busy, done, acc_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 000", {busy, done, acc_valid});
    end
  endtask

  task automatic test_normal();
    bit ok;
    job_clear();
    tile_avail = 1'b1;
    do_start(3);
    // a start while busy must not restart or resize the job
    @(posedge clk); #1;
    start = 1'b1; num_tiles = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL normal_done: done not seen within 200 cycles"); end
    n_assert++;
    if (max_run !== 12 || n_runs !== 1) begin
      n_fail++;
      $display("FAIL normal_run: got longest=%0d runs=%0d expected 12 1", max_run, n_runs);
    end
    n_assert++;
    if (total_beats !== 12) begin n_fail++; $display("FAIL normal_beats: got %0d expected 12", total_beats); end
    n_assert++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL normal_done_cnt: got %0d expected 1", done_cnt); end
    n_assert++;
    if ({err, err_cnt, busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL normal_err: got err=%0b cnt=%0d busy=%0b expected 0 0 0", err, err_cnt, busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int avail_cyc;
    job_clear();
    tile_avail = 1'b1;
    do_start(2);
    @(posedge clk); #1 tile_avail = 1'b0;
    repeat (10) @(negedge clk);
    n_assert++;
    if (total_beats !== 4 || acc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got beats=%0d acc_valid=%b expected 4 0", total_beats, acc_valid);
    end
    @(posedge clk); #1;
    tile_avail = 1'b1;
    avail_cyc  = cyc;
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL stall_done: done not seen within 100 cycles"); end
    n_assert++;
    if (n_runs !== 2 || max_run !== 4 || total_beats !== 8) begin
      n_fail++;
      $display("FAIL stall_runs: got runs=%0d longest=%0d beats=%0d expected 2 4 8", n_runs, max_run, total_beats);
    end
    n_assert++;
    if (last_run_start !== avail_cyc) begin
      n_fail++;
      $display("FAIL stall_resume: got burst at cycle %0d expected %0d", last_run_start, avail_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    job_clear();
    resp_budget = 0;
    tile_avail  = 1'b1;
    do_start(3);
    repeat (20) @(negedge clk);
    n_assert++;
    if (total_beats !== 8 || n_runs !== 1) begin
      n_fail++;
      $display("FAIL bp_stop: got beats=%0d runs=%0d expected 8 1", total_beats, n_runs);
    end
    resp_budget = 1;
    repeat (4) @(negedge clk);
    n_assert++;
    if (n_runs !== 2 || last_run_start !== resp_cyc + 1) begin
      n_fail++;
      $display("FAIL bp_resume: got runs=%0d start=%0d expected 2 %0d", n_runs, last_run_start, resp_cyc + 1);
    end
    resp_budget = 1000;
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    n_assert++;
    if (!ok || total_beats !== 12 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_finish: got done=%0b beats=%0d err=%0b expected 1 12 0", ok, total_beats, err);
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    job_clear();
    bad_y[1] = 1'b1;
    bad_y[3] = 1'b1;
    tile_avail = 1'b1;
    do_start(4);
    wait_done(200, ok);
    repeat (2) @(negedge clk);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL mm_done: done not seen within 200 cycles"); end
    n_assert++;
    if ({err, err_cnt, err_tile} !== {1'b1, 8'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL mm_final: got err=%0b cnt=%0d tile=%0d expected 1 2 1", err, err_cnt, err_tile);
    end
  endtask

  task automatic test_exp_missing();
    bit ok;
    job_clear();
    no_exp[0] = 1'b1;
    tile_avail = 1'b1;
    do_start(2);
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    n_assert++;
    if (!ok || {err, err_cnt, err_tile} !== {1'b1, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL noexp_final: got done=%0b err=%0b cnt=%0d tile=%0d expected 1 1 1 0", ok, err, err_cnt, err_tile);
    end
    n_assert++;
    if (n_pops !== 2) begin n_fail++; $display("FAIL noexp_pops: got %0d expected 2", n_pops); end
  endtask

  task automatic test_idle_ignore();
    @(negedge clk);
    man_req = 1'b1;
    repeat (4) @(negedge clk);
    n_assert++;
    if ({err, err_cnt, err_tile} !== {1'b1, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL idle_ignore: got err=%0b cnt=%0d tile=%0d expected 1 1 0", err, err_cnt, err_tile);
    end
  endtask

  task automatic test_zero_tiles();
    bit ok;
    job_clear();
    tile_avail = 1'b1;
    do_start(0);
    wait_done(10, ok);
    repeat (3) @(negedge clk);
    n_assert++;
    if (!ok || done_cnt !== 1 || n_busy !== 0 || total_beats !== 0) begin
      n_fail++;
      $display("FAIL zero_job: got done=%0b pulses=%0d busy_cyc=%0d beats=%0d expected 1 1 0 0",
               ok, done_cnt, n_busy, total_beats);
    end
    n_assert++;
    if ({err, err_cnt, err_tile} !== 17'b0) begin
      n_fail++;
      $display("FAIL zero_clear: got err=%0b cnt=%0d tile=%0d expected 0 0 0", err, err_cnt, err_tile);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    job_clear();
    expect_partial = 1'b1;
    tile_avail = 1'b1;
    do_start(2);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (acc_valid === 1'b1) n++;
    end
    #1 rst = 1'b0;
    #1;
    n_assert++;
    if ({acc_valid, src_pop, exp_pop, busy, done, err} !== 6'b0 || {err_cnt, err_tile} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got ctrl=%b cnt=%0d tile=%0d expected 000000 0 0",
               {acc_valid, src_pop, exp_pop, busy, done, err}, err_cnt, err_tile);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, acc_valid} !== 3'b0 || total_beats !== 3 || pending.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_idle: got ctrl=%b beats=%0d tiles=%0d expected 000 3 0",
               {busy, done, acc_valid}, total_beats, pending.size());
    end
    expect_partial = 1'b0;
    tile_avail = 1'b0;
  endtask

`ifdef WXYZ_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    job_clear();
    resp_budget = 0;
    tile_avail = 1'b1;
    do_start(1);
    wait_done(70000, ok);
    repeat (2) @(negedge clk);
    n_assert++;
    if (!ok || err !== 1'b1 || err_tile !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout: got done=%0b err=%0b tile=%0d expected 1 1 0", ok, err, err_tile);
    end
    pending.delete();
    resp_budget = 1000;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = '0; tile_avail = 1'b0;
    man_req = 1'b0; expect_partial = 1'b0; resp_budget = 1000; resp_cyc = 0;
    job_clear();
    test_reset();
    test_normal();
    test_stall();
    test_backpressure();
    test_mismatch();
    test_exp_missing();
    test_idle_ignore();
    test_zero_tiles();
    test_reset_mid_burst();
`ifdef WXYZ_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
